// File: rtl/key_updown_cnt.sv
// ---------------------------------------------------------------------------
// key_updown_cnt : debounced push-button modulo-(CNT_MAX+1) up/down counter
//
// Three raw push-buttons (up / down / clear) are synchronised, debounced and
// turned into single-cycle press strobes. The strobes drive a registered
// up/down counter for the seven-segment display.
//
// Ports (key_updown_cnt):
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous active-low reset
//   key_up     in   1      raw up button (async, bouncing)
//   key_down   in   1      raw down button (async, bouncing)
//   key_clr    in   1      raw clear button (async, bouncing)
//   key_times  out  CNT_W  current count, 0..CNT_MAX
//   cnt_wrap   out  1      1-cycle pulse when the count wraps either way
//   key_evt    out  1      1-cycle pulse on any accepted press
//
// Optional feature macro: KEY_REPEAT_EN
//   Defined   -> key_up/key_down auto-repeat after HOLD_CYC, then every
//                REPEAT_CYC while held.
//   Undefined -> no hold logic; a held key gives exactly one strobe.
// ---------------------------------------------------------------------------

// Per-key synchroniser + debounce FSM; emits one strobe per accepted press.
//   clk, rst_n : clock / async active-low reset
//   key_i      : raw key pin
//   strobe_o   : 1-cycle press (or repeat) strobe, combinational from state
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int KEY_ACT      = 0
`ifdef KEY_REPEAT_EN
  ,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 5_000_000,
  parameter bit REPEAT_EN    = 1'b0
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic strobe_o
);

  localparam int             DW      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYC - 1);
  // Released level of the raw pin; XOR with it maps pressed to 1.
  localparam logic           REL_LVL = (KEY_ACT != 0) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } state_e;

  logic          sync1_q, sync2_q;
  logic          pressed_s;
  state_e        state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

`ifdef KEY_REPEAT_EN
  localparam int             HMAX      = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int             HW        = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0]  REP_LAST  = HW'(REPEAT_CYC - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          rep_q, rep_d;   // 0: waiting for first repeat, 1: periodic repeat

  // Hold counter and repeat-phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= {HW{1'b0}};
      rep_q  <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      rep_q  <= rep_d;
    end
  end
`endif

  // Two-flop synchroniser, reset to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = sync2_q ^ REL_LVL;

  // Debounce FSM state and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dcnt_q  <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Debounce next-state logic and strobe generation.
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    strobe_o = 1'b0;
`ifdef KEY_REPEAT_EN
    // Hold state is cleared everywhere except while held in PRESSED.
    hcnt_d   = {HW{1'b0}};
    rep_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pressed_s) begin
          state_d = ST_PRESS_CHK;
          dcnt_d  = {DW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESS_CHK: begin
        if (!pressed_s) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == DB_LAST) begin
          state_d  = ST_PRESSED;
          strobe_o = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      ST_PRESSED: begin
        if (!pressed_s) begin
          state_d = ST_RELEASE_CHK;
          dcnt_d  = {DW{1'b0}};
        end else begin
`ifdef KEY_REPEAT_EN
          if (REPEAT_EN) begin
            if (hcnt_q == (rep_q ? REP_LAST : HOLD_LAST)) begin
              strobe_o = 1'b1;
              hcnt_d   = {HW{1'b0}};
              rep_d    = 1'b1;
            end else begin
              hcnt_d = hcnt_q + HW'(1);
              rep_d  = rep_q;
            end
          end else begin
            hcnt_d = {HW{1'b0}};
          end
`endif
          state_d = ST_PRESSED;
        end
      end
      ST_RELEASE_CHK: begin
        if (pressed_s) begin
          state_d = ST_PRESSED;
        end else if (dcnt_q == DB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        dcnt_d  = {DW{1'b0}};
      end
    endcase
  end

endmodule

// Top level: three debouncers feeding the registered up/down counter.
module key_updown_cnt #(
  parameter int CNT_W        = 4,
  parameter int CNT_MAX      = 9,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int KEY_ACT      = 0,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 5_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             key_clr,
  output logic [CNT_W-1:0] key_times,
  output logic             cnt_wrap,
  output logic             key_evt
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

  logic             up_stb_s, dn_stb_s, clr_stb_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             evt_q, evt_d;

`ifdef KEY_REPEAT_EN
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .KEY_ACT(KEY_ACT), .HOLD_CYC(HOLD_CYC),
                 .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1))
    u_db_up  (.clk(clk), .rst_n(rst_n), .key_i(key_up),   .strobe_o(up_stb_s));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .KEY_ACT(KEY_ACT), .HOLD_CYC(HOLD_CYC),
                 .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1))
    u_db_dn  (.clk(clk), .rst_n(rst_n), .key_i(key_down), .strobe_o(dn_stb_s));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .KEY_ACT(KEY_ACT), .HOLD_CYC(HOLD_CYC),
                 .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b0))
    u_db_clr (.clk(clk), .rst_n(rst_n), .key_i(key_clr),  .strobe_o(clr_stb_s));
`else
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .KEY_ACT(KEY_ACT))
    u_db_up  (.clk(clk), .rst_n(rst_n), .key_i(key_up),   .strobe_o(up_stb_s));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .KEY_ACT(KEY_ACT))
    u_db_dn  (.clk(clk), .rst_n(rst_n), .key_i(key_down), .strobe_o(dn_stb_s));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .KEY_ACT(KEY_ACT))
    u_db_clr (.clk(clk), .rst_n(rst_n), .key_i(key_clr),  .strobe_o(clr_stb_s));
`endif

  // Counter next-state: clear beats everything, up+down cancels, then up/down.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    evt_d  = up_stb_s | dn_stb_s | clr_stb_s;
    if (clr_stb_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (up_stb_s && dn_stb_s) begin
      cnt_d = cnt_q;
    end else if (up_stb_s) begin
      if (cnt_q == MAX_V) begin
        cnt_d  = {CNT_W{1'b0}};
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (dn_stb_s) begin
      if (cnt_q == {CNT_W{1'b0}}) begin
        cnt_d  = MAX_V;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Registered count and output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= {CNT_W{1'b0}};
      wrap_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      evt_q  <= evt_d;
    end
  end

  assign key_times = cnt_q;
  assign cnt_wrap  = wrap_q;
  assign key_evt   = evt_q;

endmodule
